pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Registered, parametrised program-counter unit; successor to the combinational PC+4 incrementer.
//  Holds the fetch PC and selects the next PC from:
//   - sequential (+4)
//   - conditional branch
//   - J-type jump
//   - register jump
//  Adds stall, a wrapping fetch counter and an optional return-address stack (RAS).
//  Sits between the control unit and the instruction memory.
// PARAMETERS
//  WIDTH        32           PC width in bits; must be >= 28
//  RESET_VECTOR 32'h00000000 PC value loaded on reset; must be word aligned
//  CNT_W        16           fetch_count width
//  RAS_DEPTH    4            RAS entries (power of 2, >= 2); used only with PC_RAS_EN
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        synchronous, active-high reset
//  stall        in   1        hold PC; ignore all redirects and RAS operations this cycle
//  branch_en    in   1        branch taken
//  branch_imm   in   16       raw I-type immediate (signed)
//  jump_en      in   1        J/JAL jump
//  jump_index   in   26       J-type target field
//  jr_en        in   1        register jump (JR/JALR)
//  jr_target    in   WIDTH    register jump destination
//  link         in   1        JAL/JALR: push pc_plus4 onto the RAS
//  ret          in   1        return (JR $ra): pop the RAS
//  pc           out  WIDTH    current fetch address (register)
//  pc_plus4     out  WIDTH    pc + 4, modulo 2^WIDTH (combinational)
//  fetch_count  out  CNT_W    count of non-stalled cycles since reset, wraps
//  ras_miss     out  1        one-cycle registered pulse: a ret was served from jr_target, not the RAS
// BEHAVIOUR
//  Reset (sync, on the clk edge; overrides everything, including mid-stall):
//   - pc = RESET_VECTOR; fetch_count = 0; ras_miss = 0
//   - RAS emptied (pointer and count = 0)
//  Arithmetic (all truncated to WIDTH, wrap-around silent):
//   - seq_pc   = pc_plus4
//   - br_pc    = pc_plus4 + (sext(branch_imm) << 2)
//   - j_pc     = {pc_plus4[WIDTH-1:28], jump_index, 2'b00}
//   - jr_pc    = jr_target
//  Next-PC priority, highest first:
//   - reset > stall > (jr_en | ret) > jump_en > branch_en > sequential
//   - Simultaneous branch_en & jump_en: jump wins.
//   - Simultaneous jr_en & jump_en: jr wins.
//  Latency: a redirect sampled at edge N is visible on pc after edge N (1 cycle); no delay slot.
//  Stall:
//   - pc, fetch_count and RAS are held
//   - ras_miss cleared to 0
//  fetch_count: +1 on every non-stalled, non-reset edge; wraps from 2^CNT_W-1 to 0.
// CONFIGURATION
//  PC_RAS_EN defined:
//   - link (non-stalled) pushes pc_plus4 into a circular RAS.
//   - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
//   - ret (non-stalled) with RAS non-empty: next pc = top entry, pop; jr_target ignored.
//   - ret with RAS empty: next pc = jr_target; ras_miss = 1 for the next cycle.
//   - link & ret in the same cycle (JALR $ra): pop first, then push; the count is unchanged.
//  PC_RAS_EN undefined:
//   - No RAS storage; link is ignored.
//   - ret behaves exactly as jr_en (next pc = jr_target).
//   - ras_miss tied to 0.
// TESTING
//  1. reset=1 for 2 cycles, then 5 free cycles
//     -> pc 0x0, 0x4, 0x8, 0xC, 0x10; fetch_count 0..5.
//  2. At pc=0x100: branch_en=1, branch_imm=16'hFFFC
//     -> next pc=0xF4.
//     At pc=0x100: branch_imm=16'h0003 -> next pc=0x110.
//  3. At pc=0x1000_0000: jump_en=1 & branch_en=1, jump_index=26'h0000040
//     -> next pc=0x1000_0100 (jump wins).
//  4. stall=1 for 3 cycles with jr_en=1, jr_target=0x2000
//     -> pc and fetch_count frozen.
//     Then stall=0 -> pc=0x2000 one cycle later.
//  5. pc=32'hFFFF_FFFC, no redirect
//     -> pc=0x0 (wrap).
//     Set fetch_count=0xFFFF with CNT_W=16, one free cycle -> fetch_count=0.
//  6. PC_RAS_EN, RAS_DEPTH=4: link at pc=0x10,0x20,0x30,0x40,0x50, then 5 ret with jr_target=0xDEAD_BEE0
//     -> pc 0x54, 0x44, 0x34, 0x24, then 0xDEAD_BEE0 with ras_miss=1.
//     Without PC_RAS_EN, the same stimulus -> every ret goes to 0xDEAD_BEE0; ras_miss stays 0.
//  Mid-operation reset: reset asserted while stall=1 and RAS non-empty
//     -> pc=RESET_VECTOR; a following ret sets ras_miss.

Source files
------------

// File: rtl/pc_sequencer.sv
// Registered program counter: +4 / branch / jump / register-jump redirect,
// stall, wrapping fetch counter. Optional return-address stack: PC_RAS_EN.
`timescale 1ns/1ps
module pc_sequencer #(
  parameter int              WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int              CNT_W        = 16,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [15:0]      branch_imm,
  input  logic             jump_en,
  input  logic [25:0]      jump_index,
  input  logic             jr_en,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             link,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [CNT_W-1:0] fetch_count,
  output logic             ras_miss
);

  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] br_pc;
  logic [WIDTH-1:0] j_pc;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] ras_top;
  logic             ras_hit;
  logic             miss_d;

  assign pc_plus4 = pc + WIDTH'(4);
  assign br_off   = {{(WIDTH-18){branch_imm[15]}},
                     branch_imm, 2'b00};
  assign br_pc    = pc_plus4 + br_off;

  generate
    if (WIDTH > 28) begin : g_jseg
      assign j_pc = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};
    end else begin : g_jflat
      assign j_pc = {jump_index, 2'b00};
    end
  endgenerate

  always_comb begin
    next_pc = pc_plus4;
    if (ras_hit)
      next_pc = ras_top;
    else if (jr_en | ret)
      next_pc = jr_target;
    else if (jump_en)
      next_pc = j_pc;
    else if (branch_en)
      next_pc = br_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_VECTOR;
      fetch_count <= '0;
      ras_miss    <= 1'b0;
    end else if (stall) begin
      ras_miss    <= 1'b0;
    end else begin
      pc          <= next_pc;
      fetch_count <= fetch_count + CNT_W'(1);
      ras_miss    <= miss_d;
    end
  end

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_m1;
  logic [PW-1:0]    wr_idx;
  logic [PW:0]      cnt;
  logic             ras_empty;
  logic             do_push;

  assign ptr_m1    = ptr - PW'(1);
  assign ras_empty = (cnt == '0);
  assign ras_top   = ras[ptr_m1];
  assign ras_hit   = ret & ~ras_empty;
  assign miss_d    = ret & ras_empty;
  assign do_push   = link & ~stall & ~reset;
  // pop+push in one cycle rewrites the popped slot in place
  assign wr_idx    = ras_hit ? ptr_m1 : ptr;

  always_ff @(posedge clk) begin
    if (do_push)
      ras[wr_idx] <= pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (!stall) begin
      if (ras_hit && !link) begin
        ptr <= ptr_m1;
        cnt <= cnt - 1'b1;
      end else if (!ras_hit && link) begin
        ptr <= ptr + PW'(1);
        if (cnt != FULL)
          cnt <= cnt + 1'b1;
      end
    end
  end
`else
  logic unused_link;

  assign ras_top     = '0;
  assign ras_hit     = 1'b0;
  assign miss_d      = 1'b0;
  assign unused_link = link;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, corner sequences
// and randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, branch_en, jump_en, jr_en, link, ret;
  logic [15:0] branch_imm;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [31:0] pc, pc_plus4;
  logic [15:0] fetch_count;
  logic        ras_miss;

  int checks = 0;
  int errors = 0;

`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic [31:0] m_pc;
  logic [15:0] m_cnt;
  logic        m_miss;
  logic [31:0] m_q[$];

  typedef struct {
    string       name;
    logic [31:0] start;
    logic        stl, br, jmp, jr, rt;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] tgt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .branch_en   (branch_en),
    .branch_imm  (branch_imm),
    .jump_en     (jump_en),
    .jump_index  (jump_index),
    .jr_en       (jr_en),
    .jr_target   (jr_target),
    .link        (link),
    .ret         (ret),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fetch_count (fetch_count),
    .ras_miss    (ras_miss)
  );

  function automatic vec_t mk(string n, logic [31:0] s,
      logic stl, logic br, logic jmp, logic jr, logic rt,
      logic [15:0] imm, logic [25:0] idx,
      logic [31:0] tgt, logic [31:0] e);
    vec_t v;
    v.name = n; v.start = s; v.stl = stl; v.br = br;
    v.jmp = jmp; v.jr = jr; v.rt = rt; v.imm = imm;
    v.idx = idx; v.tgt = tgt; v.exp = e;
    return v;
  endfunction

  task automatic clr();
    reset = 0; stall = 0; branch_en = 0; jump_en = 0;
    jr_en = 0; link = 0; ret = 0;
    branch_imm = '0; jump_index = '0; jr_target = '0;
  endtask

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Reference: next PC from the priority rules, RAS as a bounded queue
  task automatic model_step();
    logic [31:0] p4, np;
    logic signed [31:0] off;
    bit hit;
    if (reset) begin
      m_pc = 32'h0; m_cnt = 0; m_miss = 0;
      m_q.delete();
    end else if (stall) begin
      m_miss = 0;
    end else begin
      p4  = m_pc + 32'd4;
      off = 32'($signed(branch_imm));
      hit = RAS && ret && (m_q.size() > 0);
      if (hit)                np = m_q[$];
      else if (jr_en || ret)  np = jr_target;
      else if (jump_en)       np = {p4[31:28], jump_index, 2'b00};
      else if (branch_en)     np = p4 + 32'(off * 4);
      else                    np = p4;
      m_miss = RAS && ret && (m_q.size() == 0);
      if (RAS) begin
        if (hit) void'(m_q.pop_back());
        if (link) begin
          m_q.push_back(p4);
          if (m_q.size() > 4) void'(m_q.pop_front());
        end
      end
      m_cnt = m_cnt + 16'd1;
      m_pc  = np;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  logic [31:0] exp_pc[5];
  logic        exp_miss[5];

  initial begin
    clr();
    vecs[0]  = mk("br_neg", 32'h100, 0,1,0,0,0, 16'hFFFC, 0,
                  0, 32'hF4);
    vecs[1]  = mk("br_pos", 32'h100, 0,1,0,0,0, 16'h0003, 0,
                  0, 32'h110);
    vecs[2]  = mk("jmp_over_br", 32'h1000_0000, 0,1,1,0,0, 16'h4,
                  26'h40, 0, 32'h1000_0100);
    vecs[3]  = mk("pc_wrap", 32'hFFFF_FFFC, 0,0,0,0,0, 0, 0,
                  0, 32'h0);
    vecs[4]  = mk("jr_over_jmp", 32'h2000, 0,0,1,1,0, 0, 26'h7,
                  32'h3000, 32'h3000);
    vecs[5]  = mk("br_minneg", 32'h8000_0000, 0,1,0,0,0, 16'h8000,
                  0, 0, 32'h7FFE_0004);
    vecs[6]  = mk("jmp_maxidx", 32'hF000_0000, 0,0,1,0,0, 0,
                  26'h3FF_FFFF, 0, 32'hFFFF_FFFC);
    vecs[7]  = mk("jmp_seg_wrap", 32'hFFFF_FFFC, 0,0,1,0,0, 0,
                  26'h1, 0, 32'h4);
    vecs[8]  = mk("stall_jr", 32'h500, 1,0,0,1,0, 0, 0,
                  32'h900, 32'h500);
    vecs[9]  = mk("ret_empty", 32'h500, 0,0,0,0,1, 0, 0,
                  32'h700, 32'h700);
    vecs[10] = mk("br_maxpos", 32'h40, 0,1,0,0,0, 16'h7FFF, 0,
                  0, 32'h2_0040);

    // reset and free-running fetch
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_fc", 32'(fetch_count), 32'h0);
    chk("rst_miss", 32'(ras_miss), 32'h0);
    for (int k = 0; k < 5; k++) begin
      chk("seq_pc", pc, 32'(4 * k));
      chk("seq_fc", 32'(fetch_count), 32'(k));
      chk("seq_p4", pc_plus4, 32'(4 * k + 4));
      tick();
    end
    chk("seq_fc5", 32'(fetch_count), 32'd5);

    // stall with a pending jr: everything frozen
    jr_en = 1; jr_target = 32'h2000; stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_pc", pc, 32'h14);
      chk("stall_fc", 32'(fetch_count), 32'd5);
    end
    stall = 0;
    tick();
    chk("unstall_pc", pc, 32'h2000);
    chk("unstall_fc", 32'(fetch_count), 32'd6);
    clr();

    // vector table
    do_reset();
    foreach (vecs[i]) begin
      clr();
      jr_en = 1; jr_target = vecs[i].start;
      tick();
      chk({vecs[i].name, "_start"}, pc, vecs[i].start);
      clr();
      stall = vecs[i].stl; branch_en = vecs[i].br;
      jump_en = vecs[i].jmp; jr_en = vecs[i].jr;
      ret = vecs[i].rt; branch_imm = vecs[i].imm;
      jump_index = vecs[i].idx; jr_target = vecs[i].tgt;
      tick();
      chk(vecs[i].name, pc, vecs[i].exp);
    end
    clr();

    // fetch_count wrap
    do_reset();
    for (int i = 0; i < 70000 && fetch_count !== 16'hFFFF; i++)
      tick();
    chk("fc_max", 32'(fetch_count), 32'hFFFF);
    tick();
    chk("fc_wrap", 32'(fetch_count), 32'h0);

    // RAS overflow and miss
    do_reset();
    jr_en = 1; jr_target = 32'h10;
    tick();
    for (int a = 1; a <= 5; a++) begin
      link = 1; jr_en = 1; jr_target = 32'(16 * (a + 1));
      tick();
    end
    clr();
    exp_pc   = RAS ? '{32'h54, 32'h44, 32'h34, 32'h24, 32'hDEAD_BEE0}
                   : '{5{32'hDEAD_BEE0}};
    exp_miss = RAS ? '{0, 0, 0, 0, 1} : '{5{1'b0}};
    ret = 1; jr_target = 32'hDEAD_BEE0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("ret_pc", pc, exp_pc[k]);
      chk("ret_miss", 32'(ras_miss), 32'(exp_miss[k]));
    end
    ret = 0;
    tick();
    chk("miss_pulse", 32'(ras_miss), 32'h0);

    // reset while stalled with a non-empty RAS
    do_reset();
    link = 1;
    tick();
    link = 0; stall = 1;
    tick();
    reset = 1;
    tick();
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_fc", 32'(fetch_count), 32'h0);
    clr();
    ret = 1; jr_target = 32'h80;
    tick();
    chk("midrst_ret_pc", pc, 32'h80);
    chk("midrst_miss", 32'(ras_miss), 32'(RAS));
    clr();

    // randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(99) == 0);
      stall      = ($urandom_range(5) == 0);
      branch_en  = ($urandom_range(2) == 0);
      jump_en    = ($urandom_range(4) == 0);
      jr_en      = ($urandom_range(5) == 0);
      link       = ($urandom_range(3) == 0);
      ret        = ($urandom_range(5) == 0);
      branch_imm = 16'($urandom);
      jump_index = 26'($urandom);
      jr_target  = $urandom & 32'hFFFF_FFFC;
      tick();
      chk("rnd_pc", pc, m_pc);
      chk("rnd_p4", pc_plus4, m_pc + 32'd4);
      chk("rnd_fc", 32'(fetch_count), 32'(m_cnt));
      chk("rnd_miss", 32'(ras_miss), 32'(m_miss));
    end
    clr();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
